// File: rtl/dmem_responder_if.sv
// Load/store port between the core (master) and the data-memory responder (slave).
// Request and response each use their own valid/ready handshake.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding RV32I load/store against a word RAM.
// A request is accepted in IDLE, waits WAIT_CYCLES cycles, executes, and the
// response is held in RESP until the initiator takes it.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned halfword/word accesses are
// rejected with rsp_err instead of having their low address bits masked.
//
// state | meaning
// IDLE  | ready for a request; access runs at the accept edge when WAIT_CYCLES=0
// WAIT  | request latched, counting down to the access edge
// RESP  | response valid, held until rsp_ready
module dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic        accept;
  logic        exec;
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [2:0]  acc_f3;
  logic [AW-1:0] acc_idx;
  logic [31:0] acc_word;
  logic [31:0] acc_shift;
  logic [15:0] acc_half;
  logic        f3_ok;
  logic        misalign;
  logic        acc_err;
  logic [31:0] ld_data;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic        mem_we;
  logic        unused_addr_bits;

  assign accept = (state_q == IDLE) && bus.req_valid;

  // When the access happens at the accept edge the request is taken straight
  // from the port; otherwise the latched copy is used.
  assign acc_we    = (state_q == IDLE) ? bus.req_we     : we_q;
  assign acc_addr  = (state_q == IDLE) ? bus.req_addr   : addr_q;
  assign acc_wdata = (state_q == IDLE) ? bus.req_wdata  : wdata_q;
  assign acc_f3    = (state_q == IDLE) ? bus.req_funct3 : funct3_q;

  assign acc_idx          = acc_addr[AW+1:2];
  assign acc_word         = mem[acc_idx];
  assign unused_addr_bits = ^acc_addr[31:AW+2];

  // State and transaction registers; RAM is deliberately outside reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Next state, wait counter and the single-cycle access strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exec    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            exec    = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          exec    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request fields are captured only on the accept edge.
  always_comb begin
    we_d     = accept ? bus.req_we     : we_q;
    addr_d   = accept ? bus.req_addr   : addr_q;
    wdata_d  = accept ? bus.req_wdata  : wdata_q;
    funct3_d = accept ? bus.req_funct3 : funct3_q;
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  // Halfword needs addr[0]=0, word needs addr[1:0]=0.
  always_comb begin
    misalign = 1'b0;
    case (acc_f3[1:0])
      2'b01:   misalign = acc_addr[0];
      2'b10:   misalign = |acc_addr[1:0];
      default: misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // Decode funct3 into load extraction or store byte enables.
  always_comb begin
    ld_data   = '0;
    st_be     = '0;
    st_data   = '0;
    acc_shift = acc_word >> {acc_addr[1:0], 3'b000};
    acc_half  = acc_addr[1] ? acc_word[31:16] : acc_word[15:0];
    if (acc_we) begin
      f3_ok = (acc_f3 == 3'b000) || (acc_f3 == 3'b001) || (acc_f3 == 3'b010);
    end else begin
      f3_ok = (acc_f3 == 3'b000) || (acc_f3 == 3'b001) || (acc_f3 == 3'b010) ||
              (acc_f3 == 3'b100) || (acc_f3 == 3'b101);
    end
    acc_err = !f3_ok || misalign;
    if (!acc_err) begin
      if (acc_we) begin
        case (acc_f3)
          3'b000: begin
            st_be   = 4'b0001 << acc_addr[1:0];
            st_data = {4{acc_wdata[7:0]}};
          end
          3'b001: begin
            st_be   = acc_addr[1] ? 4'b1100 : 4'b0011;
            st_data = {2{acc_wdata[15:0]}};
          end
          default: begin
            st_be   = 4'b1111;
            st_data = acc_wdata;
          end
        endcase
      end else begin
        case (acc_f3)
          3'b000:  ld_data = {{24{acc_shift[7]}}, acc_shift[7:0]};
          3'b100:  ld_data = {24'h0, acc_shift[7:0]};
          3'b001:  ld_data = {{16{acc_half[15]}}, acc_half};
          3'b101:  ld_data = {16'h0, acc_half};
          default: ld_data = acc_word;
        endcase
      end
    end
  end

  // Response registers load on the access edge and hold through RESP.
  always_comb begin
    rdata_d = exec ? ld_data : rdata_q;
    err_d   = exec ? acc_err : err_q;
  end

  // A write is suppressed while reset is asserted so a dropped store never lands.
  assign mem_we = exec && acc_we && !acc_err && !reset;

  // Byte-enabled RAM write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem[acc_idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  // Handshake outputs follow the state directly.
  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.rsp_valid = (state_q == RESP);
    bus.rsp_rdata = rdata_q;
    bus.rsp_err   = err_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with WAIT_CYCLES=1 for the
// access tests, one with WAIT_CYCLES=3 for the mid-transaction reset case.
module tb_dmem_responder;

  logic clk;
  logic rst1;
  logic rst3;
  int   checks = 0;
  int   errors = 0;

  dmem_responder_if b1 ();
  dmem_responder_if b3 ();

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(1)) u_dut1 (
    .clk   (clk),
    .reset (rst1),
    .bus   (b1.slave)
  );

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(3)) u_dut3 (
    .clk   (clk),
    .reset (rst3),
    .bus   (b3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One transaction on the WAIT_CYCLES=1 instance; holds rsp_ready low for
  // 'hold' cycles after rsp_valid and checks the response stays put.
  task automatic txn1(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] f3, input int hold,
                      input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    @(negedge clk);
    b1.req_valid  = 1'b1;
    b1.req_we     = we;
    b1.req_addr   = addr;
    b1.req_wdata  = wdata;
    b1.req_funct3 = f3;
    chk({tag, "_req_ready"}, 32'(b1.req_ready), 32'd1);
    @(posedge clk); #1;
    b1.req_valid  = 1'b0;
    b1.req_we     = ~we;
    b1.req_addr   = ~addr;
    b1.req_wdata  = ~wdata;
    b1.req_funct3 = ~f3;
    lat = 1;
    while (!b1.rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd2);
    chk({tag, "_rdata"}, b1.rsp_rdata, exp_rd);
    chk({tag, "_err"}, 32'(b1.rsp_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(b1.rsp_valid), 32'd1);
      chk({tag, "_hold_rdata"}, b1.rsp_rdata, exp_rd);
      chk({tag, "_hold_req_ready"}, 32'(b1.req_ready), 32'd0);
    end
    b1.rsp_ready = 1'b1;
    @(posedge clk); #1;
    b1.rsp_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(b1.rsp_valid), 32'd0);
    chk({tag, "_back_idle"}, 32'(b1.req_ready), 32'd1);
  endtask

  // One transaction on the WAIT_CYCLES=3 instance.
  task automatic txn3(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] f3,
                      input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    @(negedge clk);
    b3.req_valid  = 1'b1;
    b3.req_we     = we;
    b3.req_addr   = addr;
    b3.req_wdata  = wdata;
    b3.req_funct3 = f3;
    @(posedge clk); #1;
    b3.req_valid = 1'b0;
    lat = 1;
    while (!b3.rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd4);
    chk({tag, "_rdata"}, b3.rsp_rdata, exp_rd);
    chk({tag, "_err"}, 32'(b3.rsp_err), 32'(exp_err));
    b3.rsp_ready = 1'b1;
    @(posedge clk); #1;
    b3.rsp_ready = 1'b0;
  endtask

  initial begin
    b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_addr = '0;
    b1.req_wdata = '0;   b1.req_funct3 = '0; b1.rsp_ready = 1'b0;
    b3.req_valid = 1'b0; b3.req_we = 1'b0; b3.req_addr = '0;
    b3.req_wdata = '0;   b3.req_funct3 = '0; b3.rsp_ready = 1'b0;
    rst1 = 1'b1;
    rst3 = 1'b1;
    #1;
    chk("rst_req_ready", 32'(b1.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(b1.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", b1.rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(b1.rsp_err), 32'd0);
    @(negedge clk);
    rst1 = 1'b0;
    rst3 = 1'b0;

    txn1("sw10", 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 0, 32'h0, 1'b0);
    txn1("lw10", 1'b0, 32'h10, 32'h0, 3'b010, 0, 32'hDEADBEEF, 1'b0);

    txn1("sw20", 1'b1, 32'h20, 32'h0, 3'b010, 0, 32'h0, 1'b0);
    txn1("sb20", 1'b1, 32'h20, 32'hFFFFFF11, 3'b000, 0, 32'h0, 1'b0);
    txn1("sb21", 1'b1, 32'h21, 32'hFFFFFF22, 3'b000, 0, 32'h0, 1'b0);
    txn1("sb22", 1'b1, 32'h22, 32'hFFFFFF33, 3'b000, 0, 32'h0, 1'b0);
    txn1("sb23", 1'b1, 32'h23, 32'hFFFFFF44, 3'b000, 0, 32'h0, 1'b0);
    txn1("lw20", 1'b0, 32'h20, 32'h0, 3'b010, 0, 32'h44332211, 1'b0);

    txn1("sw30", 1'b1, 32'h30, 32'h0000F080, 3'b010, 0, 32'h0, 1'b0);
    txn1("lb30", 1'b0, 32'h30, 32'h0, 3'b000, 0, 32'hFFFFFF80, 1'b0);
    txn1("lbu30", 1'b0, 32'h30, 32'h0, 3'b100, 0, 32'h00000080, 1'b0);
    txn1("lh30", 1'b0, 32'h30, 32'h0, 3'b001, 0, 32'hFFFFF080, 1'b0);
    txn1("lhu30", 1'b0, 32'h30, 32'h0, 3'b101, 0, 32'h0000F080, 1'b0);

    txn1("lw30_hold", 1'b0, 32'h30, 32'h0, 3'b010, 5, 32'h0000F080, 1'b0);

`ifdef DMEM_MISALIGN_TRAP_EN
    txn1("lw32_mis", 1'b0, 32'h32, 32'h0, 3'b010, 0, 32'h0, 1'b1);
    txn1("lh31_mis", 1'b0, 32'h31, 32'h0, 3'b001, 0, 32'h0, 1'b1);
    txn1("sw31_mis", 1'b1, 32'h31, 32'h55555555, 3'b010, 0, 32'h0, 1'b1);
    txn1("lw30_after_mis", 1'b0, 32'h30, 32'h0, 3'b010, 0, 32'h0000F080, 1'b0);
`else
    txn1("lw32_mask", 1'b0, 32'h32, 32'h0, 3'b010, 0, 32'h0000F080, 1'b0);
    txn1("lh31_mask", 1'b0, 32'h31, 32'h0, 3'b001, 0, 32'hFFFFF080, 1'b0);
`endif

    txn1("st011", 1'b1, 32'h30, 32'hFFFFFFFF, 3'b011, 0, 32'h0, 1'b1);
    txn1("lw30_after_st011", 1'b0, 32'h30, 32'h0, 3'b010, 0, 32'h0000F080, 1'b0);
    txn1("ld110", 1'b0, 32'h30, 32'h0, 3'b110, 0, 32'h0, 1'b1);

    txn1("sh32", 1'b1, 32'h32, 32'h1234ABCD, 3'b001, 0, 32'h0, 1'b0);
    txn1("lw30_after_sh", 1'b0, 32'h30, 32'h0, 3'b010, 0, 32'hABCDF080, 1'b0);
    txn1("lb33", 1'b0, 32'h33, 32'h0, 3'b000, 0, 32'hFFFFFFAB, 1'b0);
    txn1("lhu32", 1'b0, 32'h32, 32'h0, 3'b101, 0, 32'h0000ABCD, 1'b0);
    txn1("lw_wrap", 1'b0, 32'h00001030, 32'h0, 3'b010, 0, 32'hABCDF080, 1'b0);

    txn3("w3_sw40", 1'b1, 32'h40, 32'hAAAA5555, 3'b010, 32'h0, 1'b0);
    txn3("w3_lw40", 1'b0, 32'h40, 32'h0, 3'b010, 32'hAAAA5555, 1'b0);

    @(negedge clk);
    b3.req_valid  = 1'b1;
    b3.req_we     = 1'b1;
    b3.req_addr   = 32'h40;
    b3.req_wdata  = 32'h12345678;
    b3.req_funct3 = 3'b010;
    @(posedge clk); #1;
    b3.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("w3_mid_wait_ready", 32'(b3.req_ready), 32'd0);
    rst3 = 1'b1;
    #1;
    chk("w3_rst_req_ready", 32'(b3.req_ready), 32'd1);
    chk("w3_rst_rsp_valid", 32'(b3.rsp_valid), 32'd0);
    chk("w3_rst_rsp_rdata", b3.rsp_rdata, 32'h0);
    chk("w3_rst_rsp_err", 32'(b3.rsp_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst3 = 1'b0;
    txn3("w3_lw40_after_rst", 1'b0, 32'h40, 32'h0, 3'b010, 32'hAAAA5555, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
